// File: rtl/seven_seg_pkg.sv
// seven_seg_pkg: segment width, blank code and active-low {g,f,e,d,c,b,a} glyphs
package seven_seg_pkg;
  localparam int SEG_W = 7;
  localparam logic [SEG_W-1:0] SEG_BLANK = 7'b1111111;
  localparam logic [SEG_W-1:0] SEG_0 = 7'b1000000;
  localparam logic [SEG_W-1:0] SEG_1 = 7'b1111001;
  localparam logic [SEG_W-1:0] SEG_2 = 7'b0100100;
  localparam logic [SEG_W-1:0] SEG_3 = 7'b0110000;
  localparam logic [SEG_W-1:0] SEG_4 = 7'b0011001;
  localparam logic [SEG_W-1:0] SEG_5 = 7'b0010010;
  localparam logic [SEG_W-1:0] SEG_6 = 7'b0000010;
  localparam logic [SEG_W-1:0] SEG_7 = 7'b1111000;
  localparam logic [SEG_W-1:0] SEG_8 = 7'b0000000;
  localparam logic [SEG_W-1:0] SEG_9 = 7'b0010000;
  localparam logic [SEG_W-1:0] SEG_A = 7'b0001000;
  localparam logic [SEG_W-1:0] SEG_B = 7'b0000011;
  localparam logic [SEG_W-1:0] SEG_C = 7'b1000110;
  localparam logic [SEG_W-1:0] SEG_D = 7'b0100001;
  localparam logic [SEG_W-1:0] SEG_E = 7'b0000110;
  localparam logic [SEG_W-1:0] SEG_F = 7'b0001110;
endpackage

// File: rtl/seven_seg_decode.sv
// seven_seg_decode: nibble to active-low glyph; SEVEN_SEG_HEX_EN enables A-F,
// otherwise 10-15 decode to blank (decimal-only).
module seven_seg_decode
  import seven_seg_pkg::*;
(
  input  logic [3:0]       nib,
  output logic [SEG_W-1:0] seg
);
  always_comb begin
    seg = SEG_BLANK;
    case (nib)
      4'h0: seg = SEG_0;
      4'h1: seg = SEG_1;
      4'h2: seg = SEG_2;
      4'h3: seg = SEG_3;
      4'h4: seg = SEG_4;
      4'h5: seg = SEG_5;
      4'h6: seg = SEG_6;
      4'h7: seg = SEG_7;
      4'h8: seg = SEG_8;
      4'h9: seg = SEG_9;
`ifdef SEVEN_SEG_HEX_EN
      4'hA: seg = SEG_A;
      4'hB: seg = SEG_B;
      4'hC: seg = SEG_C;
      4'hD: seg = SEG_D;
      4'hE: seg = SEG_E;
      4'hF: seg = SEG_F;
`endif
      default: seg = SEG_BLANK;
    endcase
  end
endmodule

// File: rtl/seven_seg_scan_driver.sv
// seven_seg_scan_driver: multiplexed common-anode scan with shadow load and
// per-slot ghosting guard; hex glyphs via SEVEN_SEG_HEX_EN in the decoder.
module seven_seg_scan_driver
  import seven_seg_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int CLK_DIV      = 1000,
  parameter int GUARD_CYCLES = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] digits_in,
  input  logic [NUM_DIGITS-1:0]   digit_en_in,
  input  logic                    load,
  output logic [SEG_W-1:0]        segments,
  output logic [NUM_DIGITS-1:0]   anodes,
  output logic                    slot_start
);
  localparam int PW = $clog2(CLK_DIV);
  localparam int IW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;
  logic [PW-1:0]                p;
  logic [IW-1:0]                idx;
  logic [NUM_DIGITS-1:0][3:0]   sh_dig;
  logic [NUM_DIGITS-1:0]        sh_en;
  logic                         wrap;
  logic                         lit;
  logic [SEG_W-1:0]             glyph;
  assign wrap = p == PW'(CLK_DIV - 1);
  assign lit  = p >= PW'(GUARD_CYCLES) && sh_en[idx];
  seven_seg_decode u_dec (.nib(sh_dig[idx]), .seg(glyph));
  // outputs are computed from pre-edge state, giving a one-cycle pipeline
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      p          <= '0;
      idx        <= '0;
      sh_dig     <= '0;
      sh_en      <= '0;
      segments   <= SEG_BLANK;
      anodes     <= '1;
      slot_start <= 1'b0;
    end else begin
      p <= wrap ? '0 : p + 1'b1;
      if (wrap) idx <= idx == IW'(NUM_DIGITS - 1) ? '0 : idx + 1'b1;
      if (load) begin
        sh_dig <= digits_in;
        sh_en  <= digit_en_in;
      end
      segments   <= lit ? glyph : SEG_BLANK;
      anodes     <= lit ? ~(NUM_DIGITS'(1) << idx) : '1;
      slot_start <= wrap;
    end
endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// tb_seven_seg_scan_driver: randomized scenarios checked against a cycle-count
// reference model (slot = n / CLK_DIV, digit = slot % NUM_DIGITS).
module tb_seven_seg_scan_driver;
  localparam int ND = 4, CD = 8, GC = 2;
  logic clk = 0, rst = 1, load = 0;
  logic [15:0] digits_in = '0;
  logic [3:0] digit_en_in = '0;
  logic [6:0] segments;
  logic [3:0] anodes;
  logic slot_start;
  int checks = 0, errors = 0;

  seven_seg_scan_driver #(.NUM_DIGITS(ND), .CLK_DIV(CD), .GUARD_CYCLES(GC)) dut (
    .clk(clk), .rst(rst), .digits_in(digits_in), .digit_en_in(digit_en_in),
    .load(load), .segments(segments), .anodes(anodes), .slot_start(slot_start)
  );

  always #5 clk = ~clk;

  localparam logic [6:0] DEC [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
`ifdef SEVEN_SEG_HEX_EN
  localparam logic [6:0] HEX [6] = '{7'b0001000, 7'b0000011, 7'b1000110,
    7'b0100001, 7'b0000110, 7'b0001110};
`endif

  function automatic logic [6:0] glyph_of(logic [3:0] v);
    if (v < 4'd10) return DEC[v];
`ifdef SEVEN_SEG_HEX_EN
    return HEX[v - 4'd10];
`else
    return 7'b1111111;
`endif
  endfunction

  // reference model: n counts edges since reset release
  int n;
  logic [3:0] m_dig [ND];
  logic [ND-1:0] m_en;
  logic [6:0] e_seg;
  logic [3:0] e_an;
  logic e_ss;

  always @(posedge clk or posedge rst)
    if (rst) begin
      n <= 0;
      m_en <= '0;
      for (int i = 0; i < ND; i++) m_dig[i] <= 4'h0;
      e_seg <= 7'h7f;
      e_an <= 4'hf;
      e_ss <= 1'b0;
    end else begin
      n <= n + 1;
      e_ss <= (n % CD) == CD - 1;
      if ((n % CD) >= GC && m_en[(n / CD) % ND]) begin
        e_an <= ~(4'b1 << ((n / CD) % ND));
        e_seg <= glyph_of(m_dig[(n / CD) % ND]);
      end else begin
        e_an <= 4'hf;
        e_seg <= 7'h7f;
      end
      if (load) begin
        for (int i = 0; i < ND; i++) m_dig[i] <= digits_in[4*i +: 4];
        m_en <= digit_en_in;
      end
    end

  task automatic test_reset();
    bit seen;
    rst = 1;
    repeat (2) @(negedge clk);
    checks++;
    if ({segments, anodes, slot_start} !== {7'h7f, 4'hf, 1'b0}) begin
      errors++;
      $display("FAIL reset_hold got seg=%b an=%b ss=%b want 1111111 1111 0", segments, anodes, slot_start);
    end
    rst = 0;
    digits_in = 16'h8765;
    digit_en_in = 4'hf;
    load = 1;
    seen = 0;
    for (int c = 0; c < 43; c++) begin
      @(negedge clk);
      load = 0;
      checks++;
      if ({segments, anodes, slot_start} !== {e_seg, e_an, e_ss}) begin
        errors++;
        $display("FAIL reset_scan c=%0d got seg=%b an=%b ss=%b want %b %b %b", c, segments, anodes, slot_start, e_seg, e_an, e_ss);
      end
      if (!seen && anodes !== 4'hf) begin
        seen = 1;
        checks++;
        if (anodes !== 4'b1110) begin
          errors++;
          $display("FAIL first_digit got an=%b want 1110", anodes);
        end
      end
    end
    @(posedge clk);
    #3 rst = 1;
    #1;
    checks++;
    if ({segments, anodes, slot_start} !== {7'h7f, 4'hf, 1'b0}) begin
      errors++;
      $display("FAIL async_reset got seg=%b an=%b ss=%b want 1111111 1111 0", segments, anodes, slot_start);
    end
    @(negedge clk);
    rst = 0;
  endtask

  task automatic test_scan();
    logic [6:0] want [4] = '{7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001};
    logic [3:0] sel [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    digits_in = 16'h4321;
    digit_en_in = 4'hf;
    load = 1;
    for (int c = 0; c < 64; c++) begin
      @(negedge clk);
      load = 0;
      checks++;
      if ({segments, anodes, slot_start} !== {e_seg, e_an, e_ss}) begin
        errors++;
        $display("FAIL scan c=%0d got seg=%b an=%b ss=%b want %b %b %b", c, segments, anodes, slot_start, e_seg, e_an, e_ss);
      end
      for (int d = 0; d < 4; d++)
        if (anodes === sel[d]) begin
          checks++;
          if (segments !== want[d]) begin
            errors++;
            $display("FAIL scan_glyph d=%0d got seg=%b want %b", d, segments, want[d]);
          end
        end
    end
  endtask

  task automatic test_blank();
    digits_in = 16'(($urandom & 16'h7777));
    digit_en_in = 4'b0101;
    load = 1;
    for (int c = 0; c < 64; c++) begin
      @(negedge clk);
      load = 0;
      checks++;
      if ({segments, anodes, slot_start} !== {e_seg, e_an, e_ss} || anodes[1] !== 1'b1 || anodes[3] !== 1'b1) begin
        errors++;
        $display("FAIL blank c=%0d got seg=%b an=%b ss=%b want %b %b %b", c, segments, anodes, slot_start, e_seg, e_an, e_ss);
      end
    end
  endtask

  task automatic test_load_timing();
    bit found;
    digit_en_in = 4'hf;
    digits_in = 16'h1111;
    load = 1;
    @(negedge clk);
    load = 0;
    digits_in = 16'h9999;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (c == 13) load = 1;
      else load = 0;
      checks++;
      if ({segments, anodes, slot_start} !== {e_seg, e_an, e_ss}) begin
        errors++;
        $display("FAIL load_mid c=%0d got seg=%b an=%b ss=%b want %b %b %b", c, segments, anodes, slot_start, e_seg, e_an, e_ss);
      end
    end
    found = 0;
    for (int c = 0; c < 20 && !found; c++) begin
      @(negedge clk);
      found = slot_start;
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL load_sync got no slot_start want pulse within 20 cycles");
    end
    repeat (7) @(negedge clk);
    digits_in = 16'h5678;
    load = 1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      load = 0;
      checks++;
      if ({segments, anodes, slot_start} !== {e_seg, e_an, e_ss}) begin
        errors++;
        $display("FAIL load_boundary c=%0d got seg=%b an=%b ss=%b want %b %b %b", c, segments, anodes, slot_start, e_seg, e_an, e_ss);
      end
    end
  endtask

  task automatic test_hex();
`ifdef SEVEN_SEG_HEX_EN
    logic [6:0] want_a = 7'b0001000;
`else
    logic [6:0] want_a = 7'b1111111;
`endif
    digits_in = 16'hFEDA;
    digit_en_in = 4'hf;
    load = 1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      load = 0;
      checks++;
      if ({segments, anodes, slot_start} !== {e_seg, e_an, e_ss}) begin
        errors++;
        $display("FAIL hex c=%0d got seg=%b an=%b ss=%b want %b %b %b", c, segments, anodes, slot_start, e_seg, e_an, e_ss);
      end
      if (anodes === 4'b1110) begin
        checks++;
        if (segments !== want_a) begin
          errors++;
          $display("FAIL hex_a got seg=%b want %b", segments, want_a);
        end
      end
    end
  endtask

  task automatic test_wrap();
    int last_ss, last_d0, last_idx, cur;
    logic [3:0] prev_an;
    last_ss = -1;
    last_d0 = -1;
    last_idx = -1;
    prev_an = anodes;
    digits_in = 16'($urandom);
    digit_en_in = 4'hf;
    load = 1;
    for (int c = 0; c < 96; c++) begin
      @(negedge clk);
      load = 0;
      checks++;
      if ({segments, anodes, slot_start} !== {e_seg, e_an, e_ss} || $countones(~anodes) > 1) begin
        errors++;
        $display("FAIL wrap c=%0d got seg=%b an=%b ss=%b want %b %b %b", c, segments, anodes, slot_start, e_seg, e_an, e_ss);
      end
      if (slot_start) begin
        if (last_ss >= 0) begin
          checks++;
          if (c - last_ss !== CD) begin
            errors++;
            $display("FAIL slot_period got %0d want %0d", c - last_ss, CD);
          end
        end
        last_ss = c;
      end
      if (prev_an === 4'hf && anodes !== 4'hf) begin
        cur = 0;
        for (int d = 0; d < ND; d++) if (!anodes[d]) cur = d;
        if (last_idx >= 0) begin
          checks++;
          if (cur !== (last_idx + 1) % ND) begin
            errors++;
            $display("FAIL idx_seq got %0d want %0d", cur, (last_idx + 1) % ND);
          end
        end
        last_idx = cur;
        if (cur == 0) begin
          if (last_d0 >= 0) begin
            checks++;
            if (c - last_d0 !== ND * CD) begin
              errors++;
              $display("FAIL scan_period got %0d want %0d", c - last_d0, ND * CD);
            end
          end
          last_d0 = c;
        end
      end
      prev_an = anodes;
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      checks++;
      if ({segments, anodes, slot_start} !== {e_seg, e_an, e_ss}) begin
        errors++;
        $display("FAIL random c=%0d got seg=%b an=%b ss=%b want %b %b %b", c, segments, anodes, slot_start, e_seg, e_an, e_ss);
      end
      digits_in = 16'($urandom);
      digit_en_in = 4'($urandom);
      load = $urandom_range(0, 3) == 0;
    end
    load = 0;
  endtask

  initial begin
    test_reset();
    test_scan();
    test_blank();
    test_load_timing();
    test_hex();
    test_wrap();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
